// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the instruction fetch slice.
//                Default address/data widths, reset PC, halt encoding and
//                the fetch state encoding (IDLE, FETCH, HALTED).
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          ADDR_W_DEF    = 6;
    localparam int          DATA_W_DEF    = 16;
    localparam int unsigned RESET_PC_DEF  = 0;
    localparam logic [15:0] HALT_WORD_DEF = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : Two-entry {instr, pc} buffer between the instruction memory
//                response and decode: an output register plus one skid entry.
//                The upstream never sends more than the two entries can hold,
//                so there is no back-pressure output.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                flush              - drop both entries (and any input word)
//                in_valid/in_instr/in_pc - memory response this cycle
//                out_valid/out_ready/out_instr/out_pc - decode handshake
//                skid_v             - skid entry occupied (for occupancy)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              skid_v
);

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_instr;
    logic [ADDR_W-1:0] r_out_pc;
    logic              r_skid_v;
    logic [DATA_W-1:0] r_skid_instr;
    logic [ADDR_W-1:0] r_skid_pc;
    logic              w_pop;

    assign w_pop = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_skid_v     <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_skid_v    <= 1'b0;
        end else if (w_pop) begin
            if (r_skid_v) begin
                // Older skid word goes out first; a new word refills skid.
                r_out_instr <= r_skid_instr;
                r_out_pc    <= r_skid_pc;
                r_out_valid <= 1'b1;
                r_skid_v    <= in_valid;
                if (in_valid) begin
                    r_skid_instr <= in_instr;
                    r_skid_pc    <= in_pc;
                end
            end else if (in_valid) begin
                r_out_instr <= in_instr;
                r_out_pc    <= in_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (in_valid) begin
            if (!r_out_valid) begin
                r_out_instr <= in_instr;
                r_out_pc    <= in_pc;
                r_out_valid <= 1'b1;
            end else begin
                r_skid_instr <= in_instr;
                r_skid_pc    <= in_pc;
                r_skid_v     <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_pc    = r_out_pc;
    assign skid_v    = r_skid_v;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage in front of a 1-cycle sync-read
//                instruction memory. Owns the PC, issues reads, tags the
//                in-flight read and hands {instr, pc} to decode through a
//                two-entry buffer. Redirect flushes everything buffered and
//                in flight.
//  Ports       : clk, rst, run, redirect, redirect_pc
//                imem_en/imem_we/imem_addr/imem_di/imem_do - memory side
//                if_valid/if_ready/if_instr/if_pc          - decode side
//                halted                                    - halt status
//  Options     : FETCH_HALT_EN - stop fetching after a HALT_WORD response
//                (undefined: HALT_WORD is ordinary, halted tied low)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int unsigned RESET_PC  = RESET_PC_DEF,
    parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_di,
    input  logic [DATA_W-1:0] imem_do,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              halted
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic              r_req_v;
    logic [ADDR_W-1:0] r_req_pc;

    logic              w_skid_v;
    logic              w_pop;
    logic [1:0]        w_occ;
    logic              w_room;
    logic              w_issue;
    logic              w_rsp_v;
    logic              w_halt_hit;

    // A response landing in a redirect cycle is wrong-path and is dropped.
    assign w_rsp_v = r_req_v & ~redirect;

`ifdef FETCH_HALT_EN
    assign w_halt_hit = w_rsp_v & (imem_do == HALT_WORD);
    assign halted     = (r_state == S_HALTED);
`else
    logic w_unused_halt;
    assign w_unused_halt = (imem_do == HALT_WORD);
    assign w_halt_hit    = 1'b0;
    assign halted        = 1'b0;
`endif

    // Occupancy counts the in-flight read so the skid can never overflow.
    assign w_pop   = if_valid & if_ready;
    assign w_occ   = {1'b0, if_valid} + {1'b0, w_skid_v} + {1'b0, r_req_v};
    assign w_room  = (w_occ - {1'b0, w_pop}) < 2'd2;
    assign w_issue = (r_state == S_FETCH) & ~redirect & w_room;

    assign imem_en   = w_issue;
    assign imem_we   = 1'b0;
    assign imem_addr = r_pc;
    assign imem_di   = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (w_halt_hit)  w_state_nxt = S_HALTED;
                else if (!run)   w_state_nxt = S_IDLE;
            end
            S_HALTED: begin
                if (redirect) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // PC and in-flight tag. A read issued alongside a halt response is
    // discarded: no tag is recorded and the PC stays on the unfetched word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= ADDR_W'(RESET_PC);
            r_req_v  <= 1'b0;
            r_req_pc <= '0;
        end else if (redirect) begin
            r_pc    <= redirect_pc;
            r_req_v <= 1'b0;
        end else if (w_issue && !w_halt_hit) begin
            r_pc     <= r_pc + ADDR_W'(1);
            r_req_v  <= 1'b1;
            r_req_pc <= r_pc;
        end else begin
            r_req_v <= 1'b0;
        end
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .in_valid  (w_rsp_v),
        .in_instr  (imem_do),
        .in_pc     (r_req_pc),
        .out_valid (if_valid),
        .out_ready (if_ready),
        .out_instr (if_instr),
        .out_pc    (if_pc),
        .skid_v    (w_skid_v)
    );

endmodule
`default_nettype wire
